// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the white-balance frame controller.
//   wb_mode_t   - controller state, exported on wb_ctrl.mode
//   mode_en     - white-balance enable value that belongs to a state
//   mode_update - value loaded into `update` on a vsync fall in a state
package wb_pkg;

  typedef enum logic [1:0] {
    WB_INIT   = 2'd0,
    WB_BYPASS = 2'd1,
    WB_AUTO   = 2'd2,
    WB_FROZEN = 2'd3
  } wb_mode_t;

  function automatic logic mode_en(input wb_mode_t m);
    return (m == WB_AUTO) || (m == WB_FROZEN);
  endfunction

  // fcnt_last: the AUTO frame counter sits on its final frame, so the
  // frame starting at the next rise is the one that latches new gains.
  function automatic logic mode_update(input wb_mode_t m, input logic fcnt_last);
    logic u;
    case (m)
      WB_INIT, WB_BYPASS: u = 1'b1;
      WB_AUTO:            u = fcnt_last;
      default:            u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a raw active-low key and debounces it.
//   clk, rstn : clock, asynchronous active-low reset
//   key_n     : raw key, active-low, asynchronous to clk
//   press     : one-cycle pulse on a debounced 1->0 (press) transition
// A new level is accepted once the synchronized key has differed from the
// debounced level for DEBOUNCE_CYC consecutive cycles; releases are
// debounced the same way but produce no pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          s1, s2;
  logic          db;
  logic [CW-1:0] cnt;

  // Sync flops and debounced level reset to "released" so a key held
  // through reset is seen as a fresh press only after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        db    <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: frame-synchronous controller for the white-balance stage.
//   clk, rstn   : pixel clock, asynchronous active-low reset
//   vsync       : active-high frame sync, synchronous to clk
//   key_mode    : raw mode key, active-low, asynchronous
//   key_freeze  : raw freeze key, active-low, asynchronous
//   en          : white-balance enable (registered)
//   update      : gain-latch request, changes only on vsync falls
//   mode        : current state (wb_mode_t encoding)
//   upd_cnt     : number of vsync rises seen with update=1, wraps at 255
// State and en change only on a vsync rise; update changes only on a fall,
// so update is stable across every rise where the stage latches gains.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 1_000_000,
  parameter int INIT_FRAMES   = 2,
  parameter int UPDATE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       vsync,
  input  logic       key_mode,
  input  logic       key_freeze,
  output logic       en,
  output logic       update,
  output logic [1:0] mode,
  output logic [7:0] upd_cnt
);

  localparam int IW = $clog2(INIT_FRAMES + 1);
  localparam int FW = (UPDATE_FRAMES > 1) ? $clog2(UPDATE_FRAMES) : 1;

  logic          vs_d, rise, fall;
  logic          press_m, press_f;
  logic          pend_m, pend_f;
  wb_mode_t      state, nxt;
  logic [IW-1:0] icnt;
  logic [FW-1:0] fcnt;
  logic          fcnt_last, init_done;
  logic          en_d, upd_d;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_mode),
    .press (press_m)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_freeze (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_freeze),
    .press (press_f)
  );

  assign rise      = vsync & ~vs_d;
  assign fall      = ~vsync & vs_d;
  assign fcnt_last = (fcnt == FW'(UPDATE_FRAMES - 1));
  // This rise is a counted INIT frame and it is the last one needed.
  assign init_done = update && (icnt == IW'(INIT_FRAMES - 1));
  assign mode      = state;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= WB_INIT;
    else       state <= nxt;
  end

  // Next-state decode; mode beats freeze when both are pending.
  always_comb begin
    nxt = state;
    if (rise) begin
      case (state)
        WB_INIT:   if (init_done) nxt = WB_AUTO;
        WB_BYPASS: if (pend_m)    nxt = WB_AUTO;
        WB_AUTO: begin
          if (pend_m)      nxt = WB_BYPASS;
          else if (pend_f) nxt = WB_FROZEN;
        end
        WB_FROZEN: begin
          if (pend_m)      nxt = WB_BYPASS;
          else if (pend_f) nxt = WB_AUTO;
        end
        default: nxt = WB_INIT;
      endcase
    end
  end

  // Output decode: en follows the next state so it moves together with
  // mode; update is computed from the current state for the next fall.
  always_comb begin
    en_d  = mode_en(nxt);
    upd_d = mode_update(state, fcnt_last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d    <= 1'b0;
      en      <= 1'b0;
      update  <= 1'b0;
      upd_cnt <= '0;
      fcnt    <= '0;
      icnt    <= '0;
      pend_m  <= 1'b0;
      pend_f  <= 1'b0;
    end else begin
      vs_d <= vsync;
      en   <= en_d;
      if (fall) update <= upd_d;

      if (rise && update) upd_cnt <= upd_cnt + 8'd1;

      if (rise && state == WB_INIT && update) icnt <= icnt + 1'b1;

      if (rise) begin
        if (nxt == WB_AUTO && state != WB_AUTO) fcnt <= '0;
        else if (state == WB_AUTO)              fcnt <= fcnt_last ? '0 : fcnt + 1'b1;
      end

      // Every rise consumes (or, in INIT/BYPASS, discards) the pending
      // presses; a flag that is already set absorbs further presses.
      if (rise) begin
        pend_m <= 1'b0;
        pend_f <= 1'b0;
      end else begin
        if (press_m) pend_m <= 1'b1;
        if (press_f) pend_f <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;

  localparam int DB    = 4;
  localparam int INITF = 2;
  localparam int UPDF  = 3;
  localparam int NDIR  = 21;
  localparam int NRND  = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       vsync = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_freeze = 1'b1;
  logic       en, update;
  logic [1:0] mode;
  logic [7:0] upd_cnt;

  always #5 clk = ~clk;

  wb_ctrl #(.DEBOUNCE_CYC(DB), .INIT_FRAMES(INITF), .UPDATE_FRAMES(UPDF)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .vsync      (vsync),
    .key_mode   (key_mode),
    .key_freeze (key_freeze),
    .en         (en),
    .update     (update),
    .mode       (mode),
    .upd_cnt    (upd_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pressed-cycle mask for one frame (bit c = key held down in cycle c).
  function automatic logic [99:0] pat(input int s, input int l);
    logic [99:0] r;
    r = '0;
    for (int i = s; i < s + l && i < 100; i++) r[i] = 1'b1;
    return r;
  endfunction

  // A press registers if the key stays down for at least DB cycles.
  function automatic bit has_press(input logic [99:0] p);
    int run;
    run = 0;
    for (int i = 0; i < 100; i++) begin
      run = p[i] ? run + 1 : 0;
      if (run >= DB) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [99:0] rand_pat();
    logic [99:0] r;
    r = '0;
    for (int s = 0; s < 3; s++)
      if ($urandom_range(0, 2) == 0) r |= pat(15 + 25 * s, $urandom_range(1, 12));
    return r;
  endfunction

  // Frame-level reference model: one step per rise, one per fall.
  int mm, mf, mucnt, mic;
  bit me, mu, mpm, mpf;

  task automatic model_reset();
    mm = 0; mf = 0; mucnt = 0; mic = 0;
    me = 0; mu = 0; mpm = 0; mpf = 0;
  endtask

  task automatic model_rise();
    if (mu) mucnt = (mucnt + 1) % 256;
    case (mm)
      0: if (mu) begin
           mic++;
           if (mic >= INITF) begin mm = 2; mf = 0; end
         end
      1: if (mpm) begin mm = 2; mf = 0; end
      2: if (mpm) mm = 1;
         else if (mpf) mm = 3;
         else mf = (mf + 1) % UPDF;
      default: if (mpm) mm = 1;
               else if (mpf) begin mm = 2; mf = 0; end
    endcase
    me  = (mm == 2 || mm == 3);
    mpm = 0;
    mpf = 0;
  endtask

  task automatic model_fall();
    mu = (mm == 0 || mm == 1) ? 1'b1 : (mm == 2) ? (mf == UPDF - 1) : 1'b0;
  endtask

  // One 100-cycle frame: vsync high for cycles 0..9, keys from masks.
  logic [1:0] c_m0, c_mend;
  logic       c_e0, c_ur, c_uf;
  logic [7:0] c_u0;

  task automatic run_frame(input logic [99:0] pm, input logic [99:0] pf);
    for (int c = 0; c < 100; c++) begin
      vsync      = (c < 10);
      key_mode   = ~pm[c];
      key_freeze = ~pf[c];
      tick();
      if (c == 0) begin c_m0 = mode; c_e0 = en; c_u0 = upd_cnt; c_ur = update; end
      if (c == 10) c_uf = update;
      if (c == 99) c_mend = mode;
    end
  endtask

  typedef struct {
    logic [99:0] pm, pf;
    int          mode;
    bit          en;
    int          ucnt;
    bit          uf;
  } vec_t;

  vec_t vt[NDIR];

  task automatic setv(input int i, input logic [99:0] pm, input logic [99:0] pf,
                      input int m, input bit e, input int u, input bit uf);
    vt[i].pm = pm; vt[i].pf = pf; vt[i].mode = m; vt[i].en = e;
    vt[i].ucnt = u; vt[i].uf = uf;
  endtask

  initial begin
    logic [99:0] none, pm, pf;
    bit prev_uf, xur;
    none = '0;

    // mode, en, upd_cnt after the frame's rise; update after its fall.
    setv( 0, none, none, 0, 0, 0, 1);
    setv( 1, none, none, 0, 0, 1, 1);
    setv( 2, none, none, 2, 1, 2, 0);
    setv( 3, none, none, 2, 1, 2, 0);
    setv( 4, none, none, 2, 1, 2, 1);
    setv( 5, none, none, 2, 1, 3, 0);
    setv( 6, none, none, 2, 1, 3, 0);
    setv( 7, none, none, 2, 1, 3, 1);
    setv( 8, none, pat(30, 10), 2, 1, 4, 0);
    setv( 9, none, none, 3, 1, 4, 0);
    setv(10, pat(30, 2), none, 3, 1, 4, 0);
    setv(11, none, pat(30, 10), 3, 1, 4, 0);
    setv(12, none, none, 2, 1, 4, 0);
    setv(13, pat(30, 10), none, 2, 1, 4, 0);
    setv(14, none, none, 1, 0, 4, 1);
    setv(15, pat(30, 10), none, 1, 0, 5, 1);
    setv(16, pat(30, 10), pat(40, 10), 2, 1, 6, 0);
    setv(17, none, none, 1, 0, 6, 1);
    setv(18, pat(15, 10) | pat(40, 10) | pat(65, 10), none, 1, 0, 7, 1);
    setv(19, none, pat(30, 10), 2, 1, 8, 0);
    setv(20, none, none, 3, 1, 8, 0);

    // Reset state.
    model_reset();
    repeat (3) tick();
    chk("reset en", en, 0);
    chk("reset update", update, 0);
    chk("reset mode", mode, 0);
    chk("reset upd_cnt", upd_cnt, 0);
    rstn = 1'b1;
    repeat (5) tick();

    // Directed frames from the table; model tracks along.
    prev_uf = 1'b0;
    for (int i = 0; i < NDIR; i++) begin
      run_frame(vt[i].pm, vt[i].pf);
      model_rise();
      model_fall();
      mpm = has_press(vt[i].pm);
      mpf = has_press(vt[i].pf);
      chk($sformatf("dir%0d mode", i), c_m0, vt[i].mode);
      chk($sformatf("dir%0d en", i), c_e0, vt[i].en);
      chk($sformatf("dir%0d upd_cnt", i), c_u0, vt[i].ucnt);
      chk($sformatf("dir%0d update@rise", i), c_ur, prev_uf);
      chk($sformatf("dir%0d update@fall", i), c_uf, vt[i].uf);
      chk($sformatf("dir%0d mode@end", i), c_mend, vt[i].mode);
      prev_uf = vt[i].uf;
    end

    // Reset mid-frame while FROZEN.
    for (int c = 0; c < 100; c++) begin
      vsync = (c < 10);
      key_mode = 1'b1;
      key_freeze = 1'b1;
      if (c == 50) begin
        rstn = 1'b0;
        #1;
        chk("midrst en", en, 0);
        chk("midrst update", update, 0);
        chk("midrst mode", mode, 0);
        chk("midrst upd_cnt", upd_cnt, 0);
      end
      if (c == 60) rstn = 1'b1;
      tick();
      if (c == 0) chk("prerst mode", mode, 3);
    end
    model_reset();

    // Startup repeats after the mid-frame reset.
    for (int i = 0; i < 3; i++) begin
      run_frame(none, none);
      model_rise();
      model_fall();
      chk($sformatf("restart%0d mode", i), c_m0, (i == 2) ? 2 : 0);
      chk($sformatf("restart%0d en", i), c_e0, (i == 2) ? 1 : 0);
      chk($sformatf("restart%0d upd_cnt", i), c_u0, i);
      chk($sformatf("restart%0d update@fall", i), c_uf, (i == 2) ? 0 : 1);
    end

    // Random key activity against the frame-level model.
    for (int i = 0; i < NRND; i++) begin
      pm = rand_pat();
      pf = rand_pat();
      run_frame(pm, pf);
      xur = mu;
      model_rise();
      model_fall();
      chk($sformatf("rnd%0d mode", i), c_m0, mm);
      chk($sformatf("rnd%0d en", i), c_e0, me);
      chk($sformatf("rnd%0d upd_cnt", i), c_u0, mucnt);
      chk($sformatf("rnd%0d update@rise", i), c_ur, xur);
      chk($sformatf("rnd%0d update@fall", i), c_uf, mu);
      chk($sformatf("rnd%0d mode@end", i), c_mend, mm);
      mpm = has_press(pm);
      mpf = has_press(pf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
